// File: rtl/vga_pkg.sv
// Shared 1024x768 video constants, RGB type and the 12-bit span compare
// used by pixel stages so edge sums never wrap.
package vga_pkg;
  localparam int SCREEN_W   = 1024;
  localparam int SCREEN_H   = 768;
  localparam int RGB_W      = 24;
  localparam int COORD_W    = 12;
  localparam logic SYNC_ACTIVE = 1'b0;
  localparam logic SYNC_IDLE   = 1'b1;

  typedef logic [RGB_W-1:0]   rgb_t;
  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_span(coord_t c, coord_t lo, coord_t len);
    return (c >= lo) && (c < (lo + len));
  endfunction
endpackage

// File: rtl/bouncing_box_if.sv
// Video timing bundle: raw timing-generator signals in, aligned pixel and
// delayed syncs out. Master is the timing/video side, slave the pixel stage.
interface bouncing_box_if;
  import vga_pkg::*;

  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync_in;
  logic        vsync_in;
  logic        blank_in;
  rgb_t        pixel_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        blank_out;

  modport master (
    output hcount, vcount, hsync_in, vsync_in, blank_in,
    input  pixel_out, hsync_out, vsync_out, blank_out
  );

  modport slave (
    input  hcount, vcount, hsync_in, vsync_in, blank_in,
    output pixel_out, hsync_out, vsync_out, blank_out
  );
endinterface

// File: rtl/bouncing_box_axis_bounce.sv
// One axis of box motion: steps pos by speed on each enabled tick and reflects
// at 0 and LIM_W. flip is combinational, high in the cycle the reflecting tick is seen.
module axis_bounce
  import vga_pkg::*;
#(
  parameter int POS_W = 11,
  parameter int LIM_W = 960,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             en,
  input  logic [3:0]       speed,
  output logic [POS_W-1:0] pos,
  output logic             flip
);
  localparam coord_t LIM = coord_t'(LIM_W);

  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;  // 0: increasing, 1: decreasing
  coord_t           pos_w, spd_w, sum_w, dif_w;

  always_comb begin
    pos_w = coord_t'(pos_q);
    spd_w = coord_t'(speed);
    sum_w = pos_w + spd_w;
    dif_w = pos_w - spd_w;
    pos_d = pos_q;
    dir_d = dir_q;
    flip  = 1'b0;
    if (tick && en) begin
      if (!dir_q) begin
        if (sum_w >= LIM) begin
          pos_d = POS_W'(LIM);
          dir_d = 1'b1;
          flip  = 1'b1;
        end else begin
          pos_d = POS_W'(sum_w);
        end
      end else begin
        if (pos_w <= spd_w) begin
          pos_d = '0;
          dir_d = 1'b0;
          flip  = 1'b1;
        end else begin
          pos_d = POS_W'(dif_w);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= POS_W'(INIT);
      dir_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;
endmodule

// File: rtl/bouncing_box.sv
// Draws a solid box that moves once per frame and bounces off the screen edges.
// Pixel and syncs are delayed 2 cycles together; no backpressure (streaming video).
module bouncing_box #(
  parameter int          WIDTH    = 64,
  parameter int          HEIGHT   = 64,
  parameter int          SCREEN_W = vga_pkg::SCREEN_W,
  parameter int          SCREEN_H = vga_pkg::SCREEN_H,
  parameter int          INIT_X   = 0,
  parameter int          INIT_Y   = 0,
  parameter logic [23:0] COLOR    = 24'hFFFFFF,
  parameter logic [23:0] BG       = 24'h000000
) (
  input  logic                 clk,
  input  logic                 reset,
  bouncing_box_if.slave        vid,
  input  logic                 pause,
  input  logic [3:0]           speed,
  output logic [10:0]          box_x,
  output logic [9:0]           box_y,
  output logic                 bounce
);
  import vga_pkg::*;

  logic vsync_prev_q, vsync_prev_d;
  logic tick, move_en, flip_x, flip_y;
  logic bounce_q, bounce_d;
  logic in_box_q, in_box_d;
  logic hsync_d1_q, hsync_d1_d, vsync_d1_q, vsync_d1_d, blank_d1_q, blank_d1_d;
  rgb_t pixel_q, pixel_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;

  // Falling vsync edge lands in vertical blanking, so moving here never tears.
  assign tick    = vsync_prev_q & ~vid.vsync_in;
  assign move_en = ~pause & (speed != 4'd0);

  axis_bounce #(.POS_W(11), .LIM_W(SCREEN_W - WIDTH), .INIT(INIT_X)) u_axis_x (
    .clk(clk), .reset(reset), .tick(tick), .en(move_en), .speed(speed),
    .pos(box_x), .flip(flip_x)
  );

  axis_bounce #(.POS_W(10), .LIM_W(SCREEN_H - HEIGHT), .INIT(INIT_Y)) u_axis_y (
    .clk(clk), .reset(reset), .tick(tick), .en(move_en), .speed(speed),
    .pos(box_y), .flip(flip_y)
  );

  always_comb begin
    vsync_prev_d = vid.vsync_in;
    bounce_d     = flip_x | flip_y;
    in_box_d     = in_span(coord_t'(vid.hcount), coord_t'(box_x), coord_t'(WIDTH)) &
                   in_span(coord_t'(vid.vcount), coord_t'(box_y), coord_t'(HEIGHT));
    hsync_d1_d   = vid.hsync_in;
    vsync_d1_d   = vid.vsync_in;
    blank_d1_d   = vid.blank_in;
    pixel_d      = blank_d1_q ? '0 : (in_box_q ? COLOR : BG);
    hsync_d      = hsync_d1_q;
    vsync_d      = vsync_d1_q;
    blank_d      = blank_d1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_prev_q <= SYNC_IDLE;
      bounce_q     <= 1'b0;
      in_box_q     <= 1'b0;
      hsync_d1_q   <= SYNC_IDLE;
      vsync_d1_q   <= SYNC_IDLE;
      blank_d1_q   <= 1'b1;
      pixel_q      <= '0;
      hsync_q      <= SYNC_IDLE;
      vsync_q      <= SYNC_IDLE;
      blank_q      <= 1'b1;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      bounce_q     <= bounce_d;
      in_box_q     <= in_box_d;
      hsync_d1_q   <= hsync_d1_d;
      vsync_d1_q   <= vsync_d1_d;
      blank_d1_q   <= blank_d1_d;
      pixel_q      <= pixel_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      blank_q      <= blank_d;
    end
  end

  assign bounce        = bounce_q;
  assign vid.pixel_out = pixel_q;
  assign vid.hsync_out = hsync_q;
  assign vid.vsync_out = vsync_q;
  assign vid.blank_out = blank_q;
endmodule

// File: tb/tb_bouncing_box.sv
// Bench for bouncing_box: two instances (box at origin, box near right edge)
// share one stimulus stream; pixels/syncs are scoreboarded, motion is modelled per frame.
module tb_bouncing_box;
  localparam int W = 64;
  localparam int H = 64;
  localparam int LIM_X = 1024 - W;
  localparam int LIM_Y = 768 - H;
  localparam logic [23:0] COL = 24'hFFFFFF;
  localparam logic [23:0] BGC = 24'h000000;

  typedef struct {
    logic [23:0] pix0;
    logic [23:0] pix1;
    logic        hs;
    logic        vs;
    logic        bl;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pause = 1'b0;
  logic [3:0]  speed = 4'd0;
  logic [10:0] box_x0, box_x1;
  logic [9:0]  box_y0, box_y1;
  logic        bounce0, bounce1;

  bouncing_box_if vid0();
  bouncing_box_if vid1();

  assign vid1.hcount   = vid0.hcount;
  assign vid1.vcount   = vid0.vcount;
  assign vid1.hsync_in = vid0.hsync_in;
  assign vid1.vsync_in = vid0.vsync_in;
  assign vid1.blank_in = vid0.blank_in;

  bouncing_box #(.WIDTH(W), .HEIGHT(H), .INIT_X(0), .INIT_Y(0)) dut0 (
    .clk(clk), .reset(reset), .vid(vid0), .pause(pause), .speed(speed),
    .box_x(box_x0), .box_y(box_y0), .bounce(bounce0)
  );

  bouncing_box #(.WIDTH(W), .HEIGHT(H), .INIT_X(958), .INIT_Y(0)) dut1 (
    .clk(clk), .reset(reset), .vid(vid1), .pause(pause), .speed(speed),
    .box_x(box_x1), .box_y(box_y1), .bounce(bounce1)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   mx[2], my[2];
  bit   dxm[2], dym[2];
  bit   vs_prev_m;
  int   cnt_b0, cnt_b1;
  int   init_x[2] = '{0, 958};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_pix(int h, int v, bit bl, int bx, int by);
    if (bl) return 24'h0;
    if (h >= bx && h < bx + W && v >= by && v < by + H) return COL;
    return BGC;
  endfunction

  task automatic axis_model(input int pos, input bit dir, input int lim, input int spd,
                            output int npos, output bit ndir, output bit flip);
    npos = pos; ndir = dir; flip = 1'b0;
    if (!dir) begin
      if (pos + spd >= lim) begin npos = lim; ndir = 1'b1; flip = 1'b1; end
      else npos = pos + spd;
    end else begin
      if (pos <= spd) begin npos = 0; ndir = 1'b0; flip = 1'b1; end
      else npos = pos - spd;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = init_x[i]; my[i] = 0; dxm[i] = 1'b0; dym[i] = 1'b0;
    end
    vs_prev_m = 1'b1;
    exp_q.delete();
  endtask

  task automatic step(input int h, input int v, input bit hs, input bit vs, input bit bl, input bit rst);
    exp_t e;
    bit   fx, fy;
    bit   fb[2];
    fb[0] = 1'b0; fb[1] = 1'b0;
    vid0.hcount = 11'(h); vid0.vcount = 10'(v);
    vid0.hsync_in = hs; vid0.vsync_in = vs; vid0.blank_in = bl;
    reset = rst;
    if (!rst) begin
      e.pix0 = model_pix(h, v, bl, mx[0], my[0]);
      e.pix1 = model_pix(h, v, bl, mx[1], my[1]);
      e.hs = hs; e.vs = vs; e.bl = bl;
      exp_q.push_back(e);
      if (vs_prev_m && !vs && !pause && speed != 4'd0) begin
        for (int i = 0; i < 2; i++) begin
          axis_model(mx[i], dxm[i], LIM_X, int'(speed), mx[i], dxm[i], fx);
          axis_model(my[i], dym[i], LIM_Y, int'(speed), my[i], dym[i], fy);
          fb[i] = fx | fy;
        end
      end
      vs_prev_m = vs;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
      check_eq("rst_pixel0", vid0.pixel_out, 0);
      check_eq("rst_pixel1", vid1.pixel_out, 0);
      check_eq("rst_hsync", vid0.hsync_out, 1);
      check_eq("rst_vsync", vid0.vsync_out, 1);
      check_eq("rst_blank", vid0.blank_out, 1);
      check_eq("rst_bounce0", bounce0, 0);
      check_eq("rst_bounce1", bounce1, 0);
      check_eq("rst_box_x0", box_x0, 0);
      check_eq("rst_box_x1", box_x1, 958);
      check_eq("rst_box_y0", box_y0, 0);
    end else begin
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        check_eq("pixel0", vid0.pixel_out, e.pix0);
        check_eq("pixel1", vid1.pixel_out, e.pix1);
        check_eq("hsync_out", vid0.hsync_out, e.hs);
        check_eq("vsync_out", vid0.vsync_out, e.vs);
        check_eq("blank_out", vid0.blank_out, e.bl);
      end
      check_eq("box_x0", box_x0, mx[0]);
      check_eq("box_y0", box_y0, my[0]);
      check_eq("box_x1", box_x1, mx[1]);
      check_eq("box_y1", box_y1, my[1]);
      check_eq("bounce0", bounce0, fb[0]);
      check_eq("bounce1", bounce1, fb[1]);
      cnt_b0 += int'(bounce0);
      cnt_b1 += int'(bounce1);
    end
  endtask

  int rt_h[8]  = '{10, 64, 10, 63, 63, 0, 960, 1022};
  int rt_v[8]  = '{10, 10, 10, 63, 64, 0, 5, 5};
  bit rt_b[8]  = '{0, 0, 1, 0, 0, 0, 0, 0};
  logic [11:0] hs_pat = 12'b111100111111;
  logic [11:0] vs_pat = 12'b111111001111;
  logic [11:0] bl_pat = 12'b110011110001;
  int exp_mx0[3] = '{4, 8, 12};
  int exp_mx1[3] = '{960, 956, 952};

  initial begin
    model_reset();
    cnt_b0 = 0; cnt_b1 = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, 1);

    // Render at origin box and at the box parked near the right edge.
    for (int i = 0; i < 8; i++) step(rt_h[i], rt_v[i], 1, 1, rt_b[i], 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 1, 1, 0);

    // Sync/blank alignment; the vsync pulse is a tick with speed 0.
    for (int i = 0; i < 12; i++) step(20 + i, 20, hs_pat[i], vs_pat[i], bl_pat[i], 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 1, 1, 0);
    check_eq("hold_speed0_x0", box_x0, 0);
    check_eq("hold_speed0_x1", box_x1, 958);

    // Paused tick.
    pause = 1'b1; speed = 4'd4;
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 1, 1, 0);
    check_eq("hold_pause_x0", box_x0, 0);
    check_eq("hold_pause_y0", box_y0, 0);
    check_eq("hold_pause_x1", box_x1, 958);
    check_eq("hold_pause_bounces", cnt_b0 + cnt_b1, 0);

    // Motion: three frames at speed 4.
    pause = 1'b0;
    for (int t = 0; t < 3; t++) begin
      step(0, 0, 1, 0, 1, 0);
      check_eq("motion_x0", box_x0, exp_mx0[t]);
      check_eq("motion_y0", box_y0, exp_mx0[t]);
      check_eq("edge_x1", box_x1, exp_mx1[t]);
      step(0, 0, 1, 0, 1, 0);
      step(0, 0, 1, 1, 1, 0);
      step(0, 0, 1, 1, 1, 0);
    end
    check_eq("bounce0_count", cnt_b0, 0);
    check_eq("bounce1_count", cnt_b1, 1);

    // Reset mid-frame with hsync held active and box moved.
    for (int i = 0; i < 3; i++) step(100 + i, 300, 0, 1, 0, 0);
    step(103, 300, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(10, 10, 1, 1, 0, 0);
    step(64, 10, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end
endmodule
